// File: rtl/uart_pkg.sv
// Shared UART receiver/transmitter types and constants.
// The parity state exists only when UART_RECV_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RECV_PARITY_EN
        StParity,
`endif
        StStop,
        StWaitHigh
    } uart_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Parity bit that makes the frame even (odd = 0) or odd (odd = 1).
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; a push while full
// is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_q];
    assign count   = count_q;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= wdata;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_recv_fifo.sv
// UART receiver with 2-flop input synchroniser and receive FIFO.
// Define UART_RECV_PARITY_EN to add a parity bit check (PARITY_ODD selects odd).
module uart_recv_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 25,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
`ifdef UART_RECV_PARITY_EN
    ,
    parameter bit          PARITY_ODD = 1'b0
`endif
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic                          uart_rxd,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_overrun
);

    localparam logic [7:0] TICK_HALF = 8'(CLK_DIV / 2);
    localparam logic [7:0] TICK_LAST = 8'(CLK_DIV - 1);
    localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

    logic [1:0]           sync_q;
    logic                 rxd_prev_q;
    logic                 rxd_s, fall;
    uart_state_e          state_q, state_d;
    logic [7:0]           timer_q, timer_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_bad_q, par_bad_d;
    logic                 push, pop, fifo_full, fifo_empty;
    logic                 frame_err_d, frame_err_q, overrun_q;
`ifdef UART_RECV_PARITY_EN
    logic                 parity_err_d, parity_err_q;
`endif

    assign rxd_s = sync_q[1];
    assign fall  = rxd_prev_q & ~rxd_s;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q       <= 2'b11;
            rxd_prev_q   <= 1'b1;
            state_q      <= StIdle;
            timer_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_bad_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef UART_RECV_PARITY_EN
            parity_err_q <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], uart_rxd};
            rxd_prev_q   <= rxd_s;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_bad_q    <= par_bad_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= push & fifo_full & ~pop;
`ifdef UART_RECV_PARITY_EN
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q + 8'd1;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_bad_d    = par_bad_q;
        push         = 1'b0;
        frame_err_d  = 1'b0;
`ifdef UART_RECV_PARITY_EN
        parity_err_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                timer_d   = '0;
                bit_cnt_d = '0;
                par_bad_d = 1'b0;
                if (fall) state_d = StStart;
            end
            StStart: begin
                if (timer_q == TICK_HALF) begin
                    timer_d = '0;
                    state_d = rxd_s ? StIdle : StData;
                end
            end
            StData: begin
                if (timer_q == TICK_LAST) begin
                    timer_d   = '0;
                    shift_d   = {rxd_s, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == DATA_LAST) begin
                        bit_cnt_d = '0;
`ifdef UART_RECV_PARITY_EN
                        state_d   = StParity;
`else
                        state_d   = StStop;
`endif
                    end
                end
            end
`ifdef UART_RECV_PARITY_EN
            StParity: begin
                if (timer_q == TICK_LAST) begin
                    timer_d = '0;
                    state_d = StStop;
                    if (rxd_s != parity_bit(8'(shift_q), PARITY_ODD ? PAR_ODD : PAR_EVEN)) begin
                        parity_err_d = 1'b1;
                        par_bad_d    = 1'b1;
                    end
                end
            end
`endif
            StStop: begin
                if (timer_q == TICK_LAST) begin
                    timer_d   = '0;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (!rxd_s) begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitHigh;
                    end else if (bit_cnt_q == STOP_LAST) begin
                        // Back to idle at mid-stop so the next start edge is not missed.
                        push    = ~par_bad_q;
                        state_d = StIdle;
                    end
                end
            end
            StWaitHigh: begin
                timer_d = '0;
                if (rxd_s) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx_valid = ~fifo_empty;
    assign pop      = rx_valid & rx_ready;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .push      (push),
        .wdata     (shift_q),
        .pop       (pop),
        .rdata     (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (rx_count)
    );

    assign rx_frame_err  = frame_err_q;
    assign rx_overrun    = overrun_q;
`ifdef UART_RECV_PARITY_EN
    assign rx_parity_err = parity_err_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_recv_fifo.sv
// Directed bench for uart_recv_fifo: basic frame, glitch, framing error,
// overrun, optional parity (UART_RECV_PARITY_EN) and reset mid-frame.
`timescale 1ns/1ps
module tb_uart_recv_fifo;

    localparam int unsigned CLK_DIV = 25;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       uart_rxd  = 1'b1;
    logic       rx_ready  = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [2:0] rx_count;
    logic       rx_frame_err, rx_parity_err, rx_overrun;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int frame_cnt = 0, parity_cnt = 0, overrun_cnt = 0, valid_cyc = 0;
    logic [7:0] got[$];
    int got_cyc[$];
    int f0, p0, o0, v0, g0, t0, lat;

    uart_recv_fifo #(
        .CLK_DIV    (CLK_DIV),
        .DATA_BITS  (8),
        .STOP_BITS  (1),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .uart_rxd      (uart_rxd),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .rx_count      (rx_count),
        .rx_frame_err  (rx_frame_err),
        .rx_parity_err (rx_parity_err),
        .rx_overrun    (rx_overrun)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Monitor samples on the falling edge, mid-cycle.
    always @(negedge sys_clk) begin
        if (rx_valid) valid_cyc <= valid_cyc + 1;
        if (rx_valid && rx_ready) begin
            got.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        if (rx_frame_err)  frame_cnt   <= frame_cnt + 1;
        if (rx_parity_err) parity_cnt  <= parity_cnt + 1;
        if (rx_overrun)    overrun_cnt <= overrun_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b);
        uart_rxd = b;
        wait_cycles(CLK_DIV);
    endtask

    // Line is left at the stop-bit value afterwards.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RECV_PARITY_EN
        send_bit(par);
`else
        if (par === 1'bz) uart_rxd = 1'b1;
`endif
        send_bit(stop);
    endtask

    task automatic snap();
        f0 = frame_cnt;
        p0 = parity_cnt;
        o0 = overrun_cnt;
        v0 = valid_cyc;
        g0 = got.size();
    endtask

    function automatic logic [7:0] got_at(input int i);
        if (i >= 0 && i < got.size()) return got[i];
        return 8'hxx;
    endfunction

    initial begin
        // Reset values
        wait_cycles(3);
        check("rst_valid", 32'(rx_valid), 32'd0);
        check("rst_count", 32'(rx_count), 32'd0);
        check("rst_data", 32'(rx_data), 32'd0);
        check("rst_frame_err", 32'(rx_frame_err), 32'd0);
        check("rst_parity_err", 32'(rx_parity_err), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        sys_rst_n = 1'b1;
        wait_cycles(5);

        // Basic 0xA5 frame
        snap();
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b1);
        wait_cycles(20);
        check("a5_count", 32'(got.size() - g0), 32'd1);
        check("a5_data", 32'(got_at(g0)), 32'hA5);
        check("a5_valid_cycles", 32'(valid_cyc - v0), 32'd1);
        lat = (g0 < got_cyc.size()) ? got_cyc[g0] - t0 : 9999;
        check("a5_latency_ok", 32'(lat <= 254), 32'd1);
        check("a5_no_frame_err", 32'(frame_cnt - f0), 32'd0);
        check("a5_fifo_empty", 32'(rx_count), 32'd0);

        // 6-cycle glitch, then 0x3C
        snap();
        uart_rxd = 1'b0;
        wait_cycles(6);
        uart_rxd = 1'b1;
        wait_cycles(60);
        check("glitch_no_valid", 32'(valid_cyc - v0), 32'd0);
        check("glitch_no_frame_err", 32'(frame_cnt - f0), 32'd0);
        check("glitch_no_overrun", 32'(overrun_cnt - o0), 32'd0);
        snap();
        send_frame(8'h3C, 1'b0, 1'b1);
        wait_cycles(20);
        check("3c_count", 32'(got.size() - g0), 32'd1);
        check("3c_data", 32'(got_at(g0)), 32'h3C);

        // 0x55 with bad stop, line held low for 30 bit-times
        snap();
        send_frame(8'h55, 1'b0, 1'b0);
        wait_cycles(30 * CLK_DIV);
        uart_rxd = 1'b1;
        wait_cycles(60);
        check("break_one_frame_err", 32'(frame_cnt - f0), 32'd1);
        check("break_no_push", 32'(got.size() - g0), 32'd0);
        snap();
        send_frame(8'h0F, 1'b0, 1'b1);
        wait_cycles(20);
        check("0f_count", 32'(got.size() - g0), 32'd1);
        check("0f_data", 32'(got_at(g0)), 32'h0F);

        // Overrun: five frames into a depth-4 FIFO with no consumer
        rx_ready = 1'b0;
        snap();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), ^8'(i), 1'b1);
        wait_cycles(20);
        check("ovr_count", 32'(rx_count), 32'd4);
        check("ovr_pulses", 32'(overrun_cnt - o0), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_head", 32'(rx_data), 32'h01);
        wait_cycles(10);
        check("ovr_head_hold", 32'(rx_data), 32'h01);
        rx_ready = 1'b1;
        wait_cycles(10);
        check("drain_count", 32'(got.size() - g0), 32'd4);
        check("drain_0", 32'(got_at(g0)), 32'h01);
        check("drain_1", 32'(got_at(g0 + 1)), 32'h02);
        check("drain_2", 32'(got_at(g0 + 2)), 32'h03);
        check("drain_3", 32'(got_at(g0 + 3)), 32'h04);
        check("drain_empty", 32'(rx_count), 32'd0);

`ifdef UART_RECV_PARITY_EN
        // Even parity: 0x81 needs parity bit 0
        snap();
        send_frame(8'h81, 1'b1, 1'b1);
        wait_cycles(20);
        check("par_bad_pulse", 32'(parity_cnt - p0), 32'd1);
        check("par_bad_no_push", 32'(got.size() - g0), 32'd0);
        snap();
        send_frame(8'h81, 1'b0, 1'b1);
        wait_cycles(20);
        check("par_good_no_err", 32'(parity_cnt - p0), 32'd0);
        check("par_good_data", 32'(got_at(g0)), 32'h81);
`endif

        // Reset during bit 4 of 0xFF
        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        wait_cycles(10);
        sys_rst_n = 1'b0;
        wait_cycles(2);
        check("midrst_valid", 32'(rx_valid), 32'd0);
        check("midrst_count", 32'(rx_count), 32'd0);
        check("midrst_data", 32'(rx_data), 32'd0);
        check("midrst_frame_err", 32'(rx_frame_err), 32'd0);
        check("midrst_overrun", 32'(rx_overrun), 32'd0);
        wait_cycles(3);
        sys_rst_n = 1'b1;
        wait_cycles(300);
        check("midrst_no_push", 32'(got.size() - g0), 32'd0);
        check("midrst_no_err", 32'(frame_cnt - f0), 32'd0);
        snap();
        send_frame(8'h42, 1'b0, 1'b1);
        wait_cycles(20);
        check("42_count", 32'(got.size() - g0), 32'd1);
        check("42_data", 32'(got_at(g0)), 32'h42);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
